// File: rtl/muldiv_pkg.sv
// Shared types and step-count helpers for the iterative multiply/divide unit.
// Opcode and state encodings live here so bench and RTL agree on them.
package muldiv_pkg;

  typedef enum logic [2:0] {
    FN_MUL    = 3'd0,
    FN_MULH   = 3'd1,
    FN_MULHSU = 3'd2,
    FN_MULHU  = 3'd3,
    FN_DIV    = 3'd4,
    FN_DIVU   = 3'd5,
    FN_REM    = 3'd6,
    FN_REMU   = 3'd7
  } fn_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  function automatic int mul_steps(input int xlen, input int unroll);
    return xlen / unroll;
  endfunction

  function automatic int div_steps(input int xlen);
    return xlen;
  endfunction

  function automatic int cnt_w(input int xlen);
    return $clog2(xlen) + 1;
  endfunction

  // Bit 1: first operand signed, bit 0: second operand signed.
  function automatic logic [1:0] op_signs(input fn_e fn);
    logic [1:0] s;
    case (fn)
      FN_MUL, FN_MULH, FN_DIV, FN_REM: s = 2'b11;
      FN_MULHSU:                       s = 2'b10;
      default:                         s = 2'b00;
    endcase
    return s;
  endfunction

  function automatic logic fn_is_div(input fn_e fn);
    logic r;
    case (fn)
      FN_DIV, FN_DIVU, FN_REM, FN_REMU: r = 1'b1;
      default:                          r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic fn_is_rem(input fn_e fn);
    logic r;
    case (fn)
      FN_REM, FN_REMU: r = 1'b1;
      default:         r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: MUL_UNROLL shift-add multiply steps or a
// single restoring divide step on the {hi, lo} accumulator.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_UNROLL = 1
)(
  input  logic              is_div,
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   operand,
  output logic [2*XLEN-1:0] acc_next
);

  logic [2*XLEN-1:0] mul_acc_s;
  logic [XLEN:0]     mul_sum_s;
  logic [XLEN:0]     div_part_s;
  logic [XLEN:0]     div_diff_s;

  // Multiply: add multiplicand into the high half when the low bit is set, then shift right.
  always_comb begin
    mul_acc_s = acc;
    mul_sum_s = {(XLEN+1){1'b0}};
    for (int i = 0; i < MUL_UNROLL; i++) begin
      if (mul_acc_s[0]) begin
        mul_sum_s = {1'b0, mul_acc_s[2*XLEN-1:XLEN]} + {1'b0, operand};
      end else begin
        mul_sum_s = {1'b0, mul_acc_s[2*XLEN-1:XLEN]};
      end
      mul_acc_s = {mul_sum_s, mul_acc_s[XLEN-1:1]};
    end
  end

  // Divide: the partial remainder stays below the divisor, so XLEN+1 bits cannot overflow.
  always_comb begin
    div_part_s = acc[2*XLEN-1:XLEN-1];
    div_diff_s = div_part_s - {1'b0, operand};
    if (!is_div) begin
      acc_next = mul_acc_s;
    end else if (div_diff_s[XLEN]) begin
      acc_next = {div_part_s[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end else begin
      acc_next = {div_diff_s[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/iter_muldiv.sv
// Iterative RISC-V M-extension multiply/divide unit, one operation in flight.
// Optional MULDIV_FAST_SPECIAL_EN: divide-by-zero and signed overflow finish in one cycle.
module iter_muldiv
  import muldiv_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int TAG_W      = 5,
  parameter int MUL_UNROLL = 1
)(
  input  logic             clock,
  input  logic             reset,
  input  logic             io_req_valid,
  output logic             io_req_ready,
  input  logic [2:0]       io_req_bits_fn,
  input  logic [XLEN-1:0]  io_req_bits_in1,
  input  logic [XLEN-1:0]  io_req_bits_in2,
  input  logic [TAG_W-1:0] io_req_bits_tag,
  input  logic             io_kill,
  output logic             io_resp_valid,
  input  logic             io_resp_ready,
  output logic [XLEN-1:0]  io_resp_bits_data,
  output logic [TAG_W-1:0] io_resp_bits_tag
);

  localparam int CW = cnt_w(XLEN);
  localparam logic [CW-1:0] MUL_LAST = CW'(mul_steps(XLEN, MUL_UNROLL) - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(div_steps(XLEN) - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);

  function automatic logic [XLEN-1:0] div_special(input logic rem, input logic zero,
                                                  input logic [XLEN-1:0] a);
    logic [XLEN-1:0] r;
    if (zero) begin
      r = rem ? a : {XLEN{1'b1}};
    end else begin
      r = rem ? {XLEN{1'b0}} : a;
    end
    return r;
  endfunction

  state_e            state_r, state_s;
  fn_e               fn_r, fn_s;
  logic [XLEN-1:0]   in1_r, in1_s, op_r, op_s;
  logic [TAG_W-1:0]  tag_r, tag_s;
  logic              neg_r, neg_s, zero_r, zero_s;
  logic [2*XLEN-1:0] acc_r, acc_s;
  logic [CW-1:0]     cnt_r, cnt_s;
  logic              req_ready_r, req_ready_s, resp_valid_r, resp_valid_s;
  logic [XLEN-1:0]   resp_data_r, resp_data_s;
  logic [TAG_W-1:0]  resp_tag_r, resp_tag_s;

  fn_e               req_fn_s;
  logic [1:0]        req_sgn_s;
  logic              req_s1_s, req_s2_s, req_zero_s, fast_s;
  logic [XLEN-1:0]   req_mag1_s, req_mag2_s;
  logic [2*XLEN-1:0] step_acc_s, prod_s;
  logic [XLEN-1:0]   mul_res_s, div_raw_s, fix_res_s;

  // Operands are iterated as magnitudes; the sign is reapplied on the way out.
  assign req_fn_s   = fn_e'(io_req_bits_fn);
  assign req_sgn_s  = op_signs(req_fn_s);
  assign req_s1_s   = req_sgn_s[1] & io_req_bits_in1[XLEN-1];
  assign req_s2_s   = req_sgn_s[0] & io_req_bits_in2[XLEN-1];
  assign req_mag1_s = req_s1_s ? ({XLEN{1'b0}} - io_req_bits_in1) : io_req_bits_in1;
  assign req_mag2_s = req_s2_s ? ({XLEN{1'b0}} - io_req_bits_in2) : io_req_bits_in2;
  assign req_zero_s = (io_req_bits_in2 == {XLEN{1'b0}});

`ifdef MULDIV_FAST_SPECIAL_EN
  logic req_ovf_s;
  assign req_ovf_s = req_sgn_s[0] && (io_req_bits_in1 == {1'b1, {(XLEN-1){1'b0}}})
                     && (io_req_bits_in2 == {XLEN{1'b1}});
  assign fast_s    = fn_is_div(req_fn_s) && (req_zero_s || req_ovf_s);
`else
  assign fast_s    = 1'b0;
`endif

  muldiv_step #(.XLEN(XLEN), .MUL_UNROLL(MUL_UNROLL)) u_step (
    .is_div   (state_r == ST_DIV),
    .acc      (acc_r),
    .operand  (op_r),
    .acc_next (step_acc_s)
  );

  assign prod_s    = neg_r ? ({(2*XLEN){1'b0}} - step_acc_s) : step_acc_s;
  assign mul_res_s = (fn_r == FN_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
  assign div_raw_s = fn_is_rem(fn_r) ? acc_r[2*XLEN-1:XLEN] : acc_r[XLEN-1:0];
  assign fix_res_s = zero_r ? div_special(fn_is_rem(fn_r), 1'b1, in1_r)
                            : (neg_r ? ({XLEN{1'b0}} - div_raw_s) : div_raw_s);

  // Next-state and next-output logic; kill beats every other transition out of a busy state.
  always_comb begin
    state_s     = state_r;
    fn_s        = fn_r;
    in1_s       = in1_r;
    op_s        = op_r;
    tag_s       = tag_r;
    neg_s       = neg_r;
    zero_s      = zero_r;
    acc_s       = acc_r;
    cnt_s       = cnt_r;
    resp_data_s = resp_data_r;
    resp_tag_s  = resp_tag_r;
    case (state_r)
      ST_IDLE: begin
        if (io_req_valid) begin
          fn_s   = req_fn_s;
          in1_s  = io_req_bits_in1;
          op_s   = req_mag2_s;
          tag_s  = io_req_bits_tag;
          zero_s = req_zero_s;
          neg_s  = fn_is_rem(req_fn_s) ? req_s1_s : (req_s1_s ^ req_s2_s);
          acc_s  = {{XLEN{1'b0}}, req_mag1_s};
          if (fast_s) begin
            state_s     = ST_DONE;
            resp_data_s = div_special(fn_is_rem(req_fn_s), req_zero_s, io_req_bits_in1);
            resp_tag_s  = io_req_bits_tag;
          end else if (fn_is_div(req_fn_s)) begin
            state_s = ST_DIV;
            cnt_s   = DIV_LAST;
          end else begin
            state_s = ST_MUL;
            cnt_s   = MUL_LAST;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_MUL, ST_DIV: begin
        if (io_kill) begin
          state_s = ST_IDLE;
        end else begin
          acc_s = step_acc_s;
          if (cnt_r != {CW{1'b0}}) begin
            cnt_s = cnt_r - CNT_ONE;
          end else if (state_r == ST_MUL) begin
            state_s     = ST_DONE;
            resp_data_s = mul_res_s;
            resp_tag_s  = tag_r;
          end else begin
            state_s = ST_FIX;
          end
        end
      end
      ST_FIX: begin
        if (io_kill) begin
          state_s = ST_IDLE;
        end else begin
          state_s     = ST_DONE;
          resp_data_s = fix_res_s;
          resp_tag_s  = tag_r;
        end
      end
      ST_DONE: begin
        if (io_kill || io_resp_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: state_s = ST_IDLE;
    endcase
    req_ready_s  = (state_s == ST_IDLE);
    resp_valid_s = (state_s == ST_DONE);
  end

  // State, datapath and registered outputs; reset abandons any operation.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      fn_r         <= FN_MUL;
      in1_r        <= {XLEN{1'b0}};
      op_r         <= {XLEN{1'b0}};
      tag_r        <= {TAG_W{1'b0}};
      neg_r        <= 1'b0;
      zero_r       <= 1'b0;
      acc_r        <= {(2*XLEN){1'b0}};
      cnt_r        <= {CW{1'b0}};
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_data_r  <= {XLEN{1'b0}};
      resp_tag_r   <= {TAG_W{1'b0}};
    end else begin
      state_r      <= state_s;
      fn_r         <= fn_s;
      in1_r        <= in1_s;
      op_r         <= op_s;
      tag_r        <= tag_s;
      neg_r        <= neg_s;
      zero_r       <= zero_s;
      acc_r        <= acc_s;
      cnt_r        <= cnt_s;
      req_ready_r  <= req_ready_s;
      resp_valid_r <= resp_valid_s;
      resp_data_r  <= resp_data_s;
      resp_tag_r   <= resp_tag_s;
    end
  end

  assign io_req_ready      = req_ready_r;
  assign io_resp_valid     = resp_valid_r;
  assign io_resp_bits_data = resp_data_r;
  assign io_resp_bits_tag  = resp_tag_r;

endmodule

// File: tb/tb_iter_muldiv.sv
// Directed, table-driven bench for iter_muldiv (XLEN=32, TAG_W=5, MUL_UNROLL=1).
// Expected special-case latency follows MULDIV_FAST_SPECIAL_EN.
module tb_iter_muldiv;

`ifdef MULDIV_FAST_SPECIAL_EN
  localparam int SL = 1;
`else
  localparam int SL = 34;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        io_req_valid = 1'b0;
  logic        io_req_ready;
  logic [2:0]  io_req_bits_fn = 3'd0;
  logic [31:0] io_req_bits_in1 = 32'd0;
  logic [31:0] io_req_bits_in2 = 32'd0;
  logic [4:0]  io_req_bits_tag = 5'd0;
  logic        io_kill = 1'b0;
  logic        io_resp_valid;
  logic        io_resp_ready = 1'b0;
  logic [31:0] io_resp_bits_data;
  logic [4:0]  io_resp_bits_tag;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  iter_muldiv #(.XLEN(32), .TAG_W(5), .MUL_UNROLL(1)) dut (
    .clock             (clock),
    .reset             (reset),
    .io_req_valid      (io_req_valid),
    .io_req_ready      (io_req_ready),
    .io_req_bits_fn    (io_req_bits_fn),
    .io_req_bits_in1   (io_req_bits_in1),
    .io_req_bits_in2   (io_req_bits_in2),
    .io_req_bits_tag   (io_req_bits_tag),
    .io_kill           (io_kill),
    .io_resp_valid     (io_resp_valid),
    .io_resp_ready     (io_resp_ready),
    .io_resp_bits_data (io_resp_bits_data),
    .io_resp_bits_tag  (io_resp_bits_tag)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[22];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Present a request from the next cycle; t0 is the cycle in which it was accepted.
  task automatic issue(input string name, input logic [2:0] fn, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tag, output int t0);
    bit acc;
    acc = 1'b0;
    t0 = 0;
    @(posedge clock); #1;
    io_req_valid = 1'b1; io_req_bits_fn = fn;
    io_req_bits_in1 = a; io_req_bits_in2 = b; io_req_bits_tag = tag;
    for (int n = 0; n < 60; n++) begin
      @(negedge clock);
      if (io_req_ready) begin acc = 1'b1; t0 = cyc; break; end
    end
    if (!acc) begin
      checks++; failures++;
      $display("FAIL %s_accept actual=no_ready required=ready", name);
    end
    @(posedge clock); #1;
    io_req_valid = 1'b0;
  endtask

  // Wait for the response, check it, hold resp_ready low for 'hold' cycles, then handshake.
  task automatic await_resp(input string name, input int t0, input int exp_lat,
                            input logic [31:0] exp_data, input logic [4:0] exp_tag, input int hold);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clock);
      if (io_resp_valid) begin seen = 1'b1; break; end
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL %s_timeout actual=no_resp required=resp", name);
      return;
    end
    check({name, "_lat"}, 64'(cyc - t0), 64'(exp_lat));
    check({name, "_data"}, 64'(io_resp_bits_data), 64'(exp_data));
    check({name, "_tag"}, 64'(io_resp_bits_tag), 64'(exp_tag));
    for (int k = 0; k < hold; k++) begin
      @(negedge clock);
      check({name, "_hold"}, {27'd0, io_resp_valid, io_resp_bits_tag, io_resp_bits_data},
            {27'd0, 1'b1, exp_tag, exp_data});
    end
    io_resp_ready = 1'b1;
    @(posedge clock); #1;
    io_resp_ready = 1'b0;
    @(negedge clock);
    check({name, "_release"}, {62'd0, io_resp_valid, io_req_ready}, 64'd1);
  endtask

  task automatic no_resp(input string name, input int ncyc);
    int hits;
    hits = 0;
    for (int n = 0; n < ncyc; n++) begin
      @(negedge clock);
      if (io_resp_valid) hits++;
    end
    check({name, "_noresp"}, 64'(hits), 64'd0);
  endtask

  initial begin
    int t0;
    vecs[0]  = '{3'd0, 32'd7,        32'd6,        5'h13, 32'd42,       33};
    vecs[1]  = '{3'd0, 32'hFFFFFFFF, 32'd5,        5'h01, 32'hFFFFFFFB, 33};
    vecs[2]  = '{3'd1, 32'h80000000, 32'h80000000, 5'h02, 32'h40000000, 33};
    vecs[3]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'h03, 32'hFFFFFFFE, 33};
    vecs[4]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'h04, 32'hFFFFFFFF, 33};
    vecs[5]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'h05, 32'h00000000, 33};
    vecs[6]  = '{3'd3, 32'h12345678, 32'h00000010, 5'h06, 32'h00000001, 33};
    vecs[7]  = '{3'd4, 32'hFFFFFFF9, 32'd2,        5'h07, 32'hFFFFFFFD, 34};
    vecs[8]  = '{3'd6, 32'hFFFFFFF9, 32'd2,        5'h08, 32'hFFFFFFFF, 34};
    vecs[9]  = '{3'd5, 32'd100,      32'd7,        5'h09, 32'd14,       34};
    vecs[10] = '{3'd7, 32'd100,      32'd7,        5'h0A, 32'd2,        34};
    vecs[11] = '{3'd4, 32'd7,        32'hFFFFFFFE, 5'h0B, 32'hFFFFFFFD, 34};
    vecs[12] = '{3'd6, 32'd7,        32'hFFFFFFFE, 5'h0C, 32'd1,        34};
    vecs[13] = '{3'd5, 32'd5,        32'd0,        5'h0D, 32'hFFFFFFFF, SL};
    vecs[14] = '{3'd7, 32'd5,        32'd0,        5'h0E, 32'd5,        SL};
    vecs[15] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 5'h0F, 32'h80000000, SL};
    vecs[16] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 5'h10, 32'd0,        SL};
    vecs[17] = '{3'd4, 32'hFFFFFFFB, 32'd0,        5'h11, 32'hFFFFFFFF, SL};
    vecs[18] = '{3'd6, 32'hFFFFFFFB, 32'd0,        5'h1F, 32'hFFFFFFFB, SL};
    vecs[19] = '{3'd5, 32'h80000000, 32'hFFFFFFFF, 5'h12, 32'd0,        34};
    vecs[20] = '{3'd1, 32'h80000000, 32'hFFFFFFFF, 5'h14, 32'd0,        33};
    vecs[21] = '{3'd2, 32'h80000000, 32'd2,        5'h15, 32'hFFFFFFFF, 33};

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_state", {26'd0, io_req_ready, io_resp_valid, io_resp_bits_tag, io_resp_bits_data},
          {26'd0, 1'b1, 1'b0, 5'd0, 32'd0});
    #1 reset = 1'b1;
    while (cyc < 9) begin @(posedge clock); #1; end

    // Vector 0 is presented in cycle 10, so its response is due in cycle 43.
    for (int i = 0; i < 22; i++) begin
      issue($sformatf("vec%0d", i), vecs[i].fn, vecs[i].a, vecs[i].b, vecs[i].tag, t0);
      if (i == 0) check("vec0_accept_cycle", 64'(t0), 64'd10);
      await_resp($sformatf("vec%0d", i), t0, vecs[i].lat, vecs[i].exp, vecs[i].tag, 0);
    end

    // resp_ready low for three cycles in DONE
    issue("hold", 3'd0, 32'd3, 32'd4, 5'h0A, t0);
    await_resp("hold", t0, 33, 32'd12, 5'h0A, 3);

    // Kill a divide at T+5, then kill while idle, then a normal multiply
    issue("kill_div", 3'd4, 32'd100, 32'd3, 5'h07, t0);
    while (cyc < t0 + 5) begin @(posedge clock); #1; end
    io_kill = 1'b1;
    @(posedge clock); #1;
    io_kill = 1'b0;
    @(negedge clock);
    check("kill_ready_cycle", {63'd0, io_req_ready}, 64'd1);
    check("kill_ready_at", 64'(cyc - t0), 64'd6);
    no_resp("kill_div", 40);
    @(posedge clock); #1;
    io_kill = 1'b1;
    @(posedge clock); #1;
    io_kill = 1'b0;
    @(negedge clock);
    check("kill_idle_ignored", {62'd0, io_req_ready, io_resp_valid}, 64'd2);
    issue("after_kill", 3'd0, 32'd9, 32'd9, 5'h1C, t0);
    await_resp("after_kill", t0, 33, 32'd81, 5'h1C, 0);

    // Kill while the response is waiting in DONE
    issue("kill_done", 3'd3, 32'd2, 32'd3, 5'h02, t0);
    for (int n = 0; n < 60; n++) begin
      @(negedge clock);
      if (io_resp_valid) break;
    end
    check("kill_done_valid", {63'd0, io_resp_valid}, 64'd1);
    io_kill = 1'b1;
    @(posedge clock); #1;
    io_kill = 1'b0;
    @(negedge clock);
    check("kill_done_state", {62'd0, io_req_ready, io_resp_valid}, 64'd2);

    // Reset in the middle of a divide
    issue("reset_div", 3'd5, 32'd1000, 32'd10, 5'h09, t0);
    while (cyc < t0 + 10) begin @(posedge clock); #1; end
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    check("reset_mid_div", {26'd0, io_req_ready, io_resp_valid, io_resp_bits_tag, io_resp_bits_data},
          {26'd0, 1'b1, 1'b0, 5'd0, 32'd0});
    no_resp("reset_div", 40);
    issue("after_reset", 3'd5, 32'd1000, 32'd10, 5'h09, t0);
    await_resp("after_reset", t0, 34, 32'd100, 5'h09, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
